pc_fetch_unit: RTL and testbench

- Consumer side of the next-PC select path: registers the program counter and fetches the instruction at that address from instruction memory over a req/ack handshake.
- Presents the instruction to decode with a valid flag.
- Loads the selector's next-PC result only when control signals that the current instruction is retired.
- Sits between the next-PC selector, instruction memory and the control unit.

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/fetch_timeout_counter.sv | 35 +++
 rtl/pc_fetch_unit.sv | 92 +++++++++
 tb/tb_pc_fetch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: FSM encoding and parameter defaults.
package pc_fetch_unit_pkg;

   localparam int          LARGURA_PAD    = 32;
   localparam logic [31:0] PC_INICIAL_PAD = 32'h0000_0000;

   typedef enum logic [2:0] {
      OCIOSO = 3'd0,
      BUSCA  = 3'd1,
      PRONTO = 3'd2,
      PARADO = 3'd3,
      ERRO   = 3'd4
   } estado_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts fetch cycles spent waiting for mem_ack; flags the cycle in which the count reaches TIMEOUT.
module fetch_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [3:0] LIMITE = 4'(TIMEOUT - 1);

   logic [3:0] cont_q, cont_d;

   always_comb begin
      cont_d = cont_q;
      if (clear_i)
         cont_d = '0;
      else if (enable_i)
         cont_d = cont_q + 4'd1;
   end

   // Expiry is flagged in the cycle whose increment makes the count equal TIMEOUT,
   // so a fetch gets exactly TIMEOUT request cycles before giving up.
   assign expired_o = enable_i && !clear_i && (cont_q == LIMITE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cont_q <= '0;
      else
         cont_q <= cont_d;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter register plus instruction fetch over a req/ack memory handshake.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int                 LARGURA    = LARGURA_PAD,
   parameter logic [LARGURA-1:0] PC_INICIAL = LARGURA'(PC_INICIAL_PAD),
   parameter int                 TIMEOUT    = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic [LARGURA-1:0] proximo_pc,
   input  logic               avancar,
   input  logic               halt,
   output logic               mem_req,
   output logic [LARGURA-1:0] mem_endereco,
   input  logic               mem_ack,
   input  logic [LARGURA-1:0] mem_dado,
   output logic [LARGURA-1:0] pc,
   output logic [LARGURA-1:0] instrucao,
   output logic               instrucao_valida,
   output logic               parado,
   output logic               erro_timeout
);

   estado_t            estado_q, estado_d;
   logic [LARGURA-1:0] pc_q, pc_d;
   logic [LARGURA-1:0] instr_q, instr_d;
   logic               expirou;
   logic               em_busca;

   assign em_busca = (estado_q == BUSCA);

   fetch_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (!em_busca || mem_ack),
      .enable_i (em_busca && !mem_ack),
      .expired_o(expirou)
   );

   always_comb begin
      estado_d = estado_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      case (estado_q)
         OCIOSO: if (iniciar) estado_d = BUSCA;
         BUSCA: begin
            // A late ack in the expiry cycle still wins over the timeout.
            if (mem_ack) begin
               instr_d  = mem_dado;
               estado_d = PRONTO;
            end else if (expirou) begin
               estado_d = ERRO;
            end
         end
         PRONTO: begin
            if (avancar) begin
               pc_d     = proximo_pc;
               estado_d = halt ? PARADO : BUSCA;
            end
         end
         PARADO: if (iniciar) estado_d = BUSCA;
         ERRO:   estado_d = ERRO;
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= OCIOSO;
         pc_q     <= PC_INICIAL;
         instr_q  <= '0;
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
      end
   end

   // Status outputs are state decodes, so they fall with the async reset immediately.
   assign mem_req          = em_busca;
   assign mem_endereco     = pc_q;
   assign pc               = pc_q;
   assign instrucao        = instr_q;
   assign instrucao_valida = (estado_q == PRONTO);
   assign parado           = (estado_q == PARADO);
   assign erro_timeout     = (estado_q == ERRO);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch, retire, delayed ack, halt, timeout and reset mid-fetch.
module tb_pc_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        iniciar, avancar, halt, mem_ack;
   logic [31:0] proximo_pc, mem_dado;
   logic        mem_req, instrucao_valida, parado, erro_timeout;
   logic [31:0] mem_endereco, pc, instrucao;

   int vecs = 0;
   int errs = 0;

   pc_fetch_unit #(.LARGURA(32), .PC_INICIAL(32'h0), .TIMEOUT(15)) dut (
      .clock           (clock),
      .reset           (reset),
      .iniciar         (iniciar),
      .proximo_pc      (proximo_pc),
      .avancar         (avancar),
      .halt            (halt),
      .mem_req         (mem_req),
      .mem_endereco    (mem_endereco),
      .mem_ack         (mem_ack),
      .mem_dado        (mem_dado),
      .pc              (pc),
      .instrucao       (instrucao),
      .instrucao_valida(instrucao_valida),
      .parado          (parado),
      .erro_timeout    (erro_timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " pc"},    pc,               32'h0);
      chk({tag, " instr"}, instrucao,        32'h0);
      chk({tag, " valid"}, instrucao_valida, 32'h0);
      chk({tag, " req"},   mem_req,          32'h0);
      chk({tag, " parado"}, parado,          32'h0);
      chk({tag, " erro"},  erro_timeout,     32'h0);
   endtask

   initial begin
      reset = 1'b0; iniciar = 1'b0; avancar = 1'b0; halt = 1'b0; mem_ack = 1'b0;
      proximo_pc = '0; mem_dado = '0;
      tick(); tick();
      chk_reset_outs("rst");
      reset = 1'b1;
      tick();
      chk("ocioso req", mem_req, 32'h0);

      // first fetch, ack in the first BUSCA cycle
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      chk("busca req", mem_req, 32'h1);
      chk("busca addr", mem_endereco, 32'h0);
      mem_ack = 1'b1; mem_dado = 32'hDEADBEEF; tick(); mem_ack = 1'b0;
      chk("f1 instr", instrucao, 32'hDEADBEEF);
      chk("f1 valid", instrucao_valida, 32'h1);
      chk("f1 req", mem_req, 32'h0);

      // halt without avancar holds
      halt = 1'b1; tick(); halt = 1'b0;
      chk("hold valid", instrucao_valida, 32'h1);
      chk("hold pc", pc, 32'h0);
      chk("hold parado", parado, 32'h0);

      // retire -> pc=5, new fetch
      proximo_pc = 32'h5; avancar = 1'b1; tick(); avancar = 1'b0;
      chk("ret pc", pc, 32'h5);
      chk("ret valid", instrucao_valida, 32'h0);
      chk("ret req", mem_req, 32'h1);
      chk("ret addr", mem_endereco, 32'h5);

      // ack arrives on 3rd BUSCA cycle; avancar outside PRONTO ignored
      proximo_pc = 32'h77; avancar = 1'b1; tick(); avancar = 1'b0;
      chk("dly req2", mem_req, 32'h1);
      chk("dly valid2", instrucao_valida, 32'h0);
      chk("dly pc2", pc, 32'h5);
      tick();
      chk("dly req3", mem_req, 32'h1);
      mem_ack = 1'b1; mem_dado = 32'h12345678; tick(); mem_ack = 1'b0;
      chk("dly valid", instrucao_valida, 32'h1);
      chk("dly instr", instrucao, 32'h12345678);
      chk("dly erro", erro_timeout, 32'h0);
      chk("dly req", mem_req, 32'h0);

      // retire with halt -> PARADO at 0x20
      proximo_pc = 32'h20; avancar = 1'b1; halt = 1'b1; tick(); avancar = 1'b0; halt = 1'b0;
      chk("halt parado", parado, 32'h1);
      chk("halt pc", pc, 32'h20);
      chk("halt req", mem_req, 32'h0);
      chk("halt valid", instrucao_valida, 32'h0);
      mem_ack = 1'b1; mem_dado = 32'hBAD0BAD0; tick(); mem_ack = 1'b0;
      chk("halt ack ign", instrucao, 32'h12345678);
      chk("halt still", parado, 32'h1);
      chk("halt req2", mem_req, 32'h0);
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      chk("resume parado", parado, 32'h0);
      chk("resume req", mem_req, 32'h1);
      chk("resume addr", mem_endereco, 32'h20);

      // no ack: 15 request cycles, then ERRO
      for (int i = 1; i <= 15; i++) begin
         chk($sformatf("to req c%0d", i), mem_req, 32'h1);
         tick();
      end
      chk("to erro", erro_timeout, 32'h1);
      chk("to req", mem_req, 32'h0);
      chk("to valid", instrucao_valida, 32'h0);
      iniciar = 1'b1; avancar = 1'b1; proximo_pc = 32'h99; mem_ack = 1'b1;
      tick(); tick();
      iniciar = 1'b0; avancar = 1'b0; mem_ack = 1'b0;
      chk("erro sticky", erro_timeout, 32'h1);
      chk("erro pc", pc, 32'h20);
      chk("erro req", mem_req, 32'h0);

      // ack on the 15th BUSCA cycle still succeeds
      reset = 1'b0; tick(); reset = 1'b1; tick();
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      for (int i = 1; i <= 14; i++) tick();
      chk("edge req15", mem_req, 32'h1);
      mem_ack = 1'b1; mem_dado = 32'hA5A5_0F0F; tick(); mem_ack = 1'b0;
      chk("edge valid", instrucao_valida, 32'h1);
      chk("edge erro", erro_timeout, 32'h0);
      chk("edge instr", instrucao, 32'hA5A5_0F0F);

      // all-ones next PC is just loaded
      proximo_pc = 32'hFFFF_FFFF; avancar = 1'b1; tick(); avancar = 1'b0;
      chk("wrap pc", pc, 32'hFFFF_FFFF);
      chk("wrap addr", mem_endereco, 32'hFFFF_FFFF);

      // reset mid-BUSCA with a late ack
      #2 reset = 1'b0;
      #1 chk("async req", mem_req, 32'h0);
      mem_ack = 1'b1; mem_dado = 32'hCAFE_F00D; tick();
      reset = 1'b1; tick(); tick(); mem_ack = 1'b0;
      chk_reset_outs("midrst");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
